switch_event_sequencer: RTL and testbench
=========================================

Name: switch_event_sequencer

Overview:
- Digital timing front-end that drives the control input of the behavioural Switch/Relais stage.
- Stores a programmed list of switching instants (the Switch "time" list) and an initial state (the Switch "init").
- Toggles a registered control line at each instant, measured in clock ticks from start.
- The downstream switch model consumes ctrl and has no timing logic of its own.

Parameters:
TW, 32, width of time entries and tick counter
DEPTH, 8, maximum number of switching instants (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
clear  input  1  empty the time list (IDLE/DONE only)
load_valid  input  1  load_time is valid
load_ready  output  1  sequencer can accept a time entry
load_time  input  TW  switching instant, ticks after start
init_state  input  1  ctrl value at start, sampled when start is accepted
start  input  1  begin sequence
abort  input  1  stop sequence, return to IDLE, keep list
ctrl  output  1  switch control (1 = on / Ron, 0 = off / Roff)
toggle  output  1  one-cycle pulse coincident with each ctrl change
busy  output  1  high in RUN
done  output  1  high in DONE
index  output  $clog2(DEPTH)+1  number of toggles performed in the current run
count  output  $clog2(DEPTH)+1  number of stored entries
order_err  output  1  sticky: a non-increasing entry was rejected

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state = IDLE; ctrl, toggle, busy, done, order_err = 0; index, count, tick counter = 0; list empty.
- States: IDLE, RUN, DONE.
- Load handshake:
  - load_ready = (state == IDLE) && (count < DEPTH).
  - An entry is transferred when load_valid && load_ready at an edge.
  - The entry must be strictly greater than the last stored entry. The first entry may be any value, including 0.
  - A violating entry is consumed (the handshake completes) but not stored; order_err is set.
  - At count == DEPTH, load_ready = 0 and load_valid is ignored.
- clear:
  - In IDLE or DONE: count = 0, index = 0, order_err = 0, state = IDLE. ctrl is held.
  - Ignored in RUN.
  - Beats load and start in the same cycle.
- start (IDLE only, count > 0 after any same-cycle load):
  - Accepted at edge E0: state = RUN, tick counter = 0, index = 0, ctrl = init_state, no toggle.
  - A load in the same cycle is stored and included in the run.
  - start with count == 0 is ignored.
  - start in RUN or DONE is ignored.
- RUN, at each edge:
  - If tick == time[index]: ctrl inverts, toggle = 1 for that cycle, index++.
  - Otherwise toggle = 0.
  - tick increments every edge in RUN.
  - Result: entry T produces its ctrl change at edge E(T+1).
- Run completion:
  - When the last entry toggles, the same edge sets state = DONE.
  - ctrl then holds its final value; busy = 0, done = 1.
  - The tick counter stops and does not wrap, because entries are bounded by TW.
- DONE:
  - Accepts clear (goes to IDLE, ctrl held).
  - Accepts start only after clear; start from DONE is ignored.
- abort:
  - In RUN: next state = IDLE, ctrl = init_state latched at start, toggle = 0, index = 0, list kept.
  - abort beats a same-cycle toggle, so no pulse is issued and index does not advance.
  - abort in IDLE or DONE is ignored.
- Reset mid-RUN: all state returns to reset values at that edge, including ctrl = 0 and an emptied list.
- Outputs:
  - busy = (state == RUN); done = (state == DONE). Both are registered state decodes.
  - toggle is registered.

Test Plan:
- Two entries, normal run: reset; load 3, 5; init_state = 0; start at E0 -> ctrl 0->1 at E4, 1->0 at E6, toggle high after E4 and E6 only, done = 1 after E6, index = 2.
- Zero entry with init high: load 0; init_state = 1; start at E0 -> ctrl 1 after E0, 0 after E1, done after E1.
- Fill and ordering: load 10, 10, 4, 20 -> count = 2, order_err = 1. Load entries up to DEPTH -> load_ready = 0 and a further load_valid is not stored. clear -> count = 0, order_err = 0.
- Abort: list {2, 8}, init_state = 0, start at E0, abort asserted so it is sampled at E9 (tick = 8) -> no toggle at E9, ctrl = 0, state IDLE, count = 2. Restart -> same waveform as the first run.
- Simultaneous events: load_valid (7) and start in the same IDLE cycle with count = 0 -> run starts, ctrl toggles at E8. clear with start in the same cycle -> stays IDLE, count = 0.
- Reset mid-run: list {5}, init_state = 1, reset asserted at tick 2 -> ctrl = 0, count = 0, busy = 0 at the next edge; no toggle ever emitted.

Source files
------------

// File: rtl/switch_event_sequencer.sv
// switch_event_sequencer
//   Timing front-end for a behavioural switch/relay stage. Holds an ordered
//   list of switching instants (ticks after start) and an initial control
//   state. Once started, it inverts the registered ctrl line at each instant.
//   The downstream switch model only consumes ctrl.
//
// Ports
//   clk        : clock, all state updates on rising edge
//   reset      : synchronous active-high reset (empties the list, ctrl = 0)
//   clear      : empty the list / leave DONE (ignored while running)
//   load_valid : load_time is valid
//   load_ready : an entry can be accepted (IDLE and list not full)
//   load_time  : switching instant, ticks after start
//   init_state : ctrl value applied when start is accepted
//   start      : begin a run (IDLE only, list non-empty)
//   abort      : stop a run, return to IDLE, keep the list
//   ctrl       : switch control (1 = on / Ron, 0 = off / Roff)
//   toggle     : one-cycle pulse coincident with each ctrl change
//   busy       : high while running
//   done       : high once the last instant has toggled
//   index      : toggles performed in the current run
//   count      : stored entries
//   order_err  : sticky, a non-increasing entry was rejected
module switch_event_sequencer #(
  parameter int TW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [TW-1:0]          load_time,
  input  logic                   init_state,
  input  logic                   start,
  input  logic                   abort,
  output logic                   ctrl,
  output logic                   toggle,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] index,
  output logic [$clog2(DEPTH):0] count,
  output logic                   order_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [TW-1:0] r_tick;
  logic [CW-1:0] r_index;
  logic [CW-1:0] r_count;
  logic          r_ctrl;
  logic          r_toggle;
  logic          r_order_err;
  logic          r_init;
  logic [TW-1:0] r_last;
  logic [TW-1:0] r_times [DEPTH];

  logic          w_clear;
  logic          w_load_fire;
  logic          w_order_ok;
  logic          w_store;
  logic [CW-1:0] w_count_after;
  logic          w_start;
  logic          w_hit;
  logic          w_last_hit;

  assign load_ready = (r_state == S_IDLE) && (r_count < DEPTH_C);

  // clear outranks load and start, so a cleared cycle stores nothing.
  assign w_clear       = clear && (r_state != S_RUN);
  assign w_load_fire   = load_valid && load_ready && !w_clear;
  assign w_order_ok    = (r_count == '0) || (load_time > r_last);
  assign w_store       = w_load_fire && w_order_ok;
  // A same-cycle load counts toward the non-empty check for start.
  assign w_count_after = r_count + CW'(w_store);
  assign w_start       = start && (r_state == S_IDLE) && !w_clear &&
                         (w_count_after != '0);

  // Entry T matches while tick == T, so its ctrl change lands on edge T+1.
  assign w_hit      = (r_state == S_RUN) && (r_tick == r_times[r_index[AW-1:0]]);
  assign w_last_hit = w_hit && ((r_index + CW'(1)) == r_count);

  // Time list storage; contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (!reset && w_store) begin
      r_times[r_count[AW-1:0]] <= load_time;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_index     <= '0;
      r_count     <= '0;
      r_ctrl      <= 1'b0;
      r_toggle    <= 1'b0;
      r_order_err <= 1'b0;
      r_init      <= 1'b0;
      r_last      <= '0;
    end else begin
      r_toggle <= 1'b0;
      if (w_clear) begin
        // ctrl deliberately held so the switch does not glitch on clear
        r_state     <= S_IDLE;
        r_count     <= '0;
        r_index     <= '0;
        r_order_err <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_load_fire) begin
              if (w_order_ok) begin
                r_count <= w_count_after;
                r_last  <= load_time;
              end else begin
                r_order_err <= 1'b1;
              end
            end
            if (w_start) begin
              r_state <= S_RUN;
              r_tick  <= '0;
              r_index <= '0;
              r_ctrl  <= init_state;
              r_init  <= init_state;
            end
          end
          S_RUN: begin
            if (abort) begin
              // abort wins over a coincident hit: no pulse, no index advance
              r_state <= S_IDLE;
              r_ctrl  <= r_init;
              r_index <= '0;
            end else begin
              r_tick <= r_tick + TW'(1);
              if (w_hit) begin
                r_ctrl   <= ~r_ctrl;
                r_toggle <= 1'b1;
                r_index  <= r_index + CW'(1);
                if (w_last_hit) begin
                  r_state <= S_DONE;
                end
              end
            end
          end
          S_DONE: begin
            // tick counter frozen; only clear (handled above) leaves DONE
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ctrl      = r_ctrl;
  assign toggle    = r_toggle;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign index     = r_index;
  assign count     = r_count;
  assign order_err = r_order_err;

endmodule

// File: tb/tb_switch_event_sequencer.sv
module tb_switch_event_sequencer;

  localparam int TW    = 32;
  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   clear;
  logic                   load_valid;
  logic                   load_ready;
  logic [TW-1:0]          load_time;
  logic                   init_state;
  logic                   start;
  logic                   abort;
  logic                   ctrl;
  logic                   toggle;
  logic                   busy;
  logic                   done;
  logic [$clog2(DEPTH):0] index;
  logic [$clog2(DEPTH):0] count;
  logic                   order_err;

  int n_checks = 0;
  int n_errors = 0;

  switch_event_sequencer #(.TW(TW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_time  (load_time),
    .init_state (init_state),
    .start      (start),
    .abort      (abort),
    .ctrl       (ctrl),
    .toggle     (toggle),
    .busy       (busy),
    .done       (done),
    .index      (index),
    .count      (count),
    .order_err  (order_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [TW-1:0] t);
    load_valid = 1'b1;
    load_time  = t;
    step();
    load_valid = 1'b0;
    $display("load %0d -> count=%0d order_err=%0d", t, count, order_err);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Checks edges E1..En after a start at E0. ta/tb are the stored instants
  // (tb < 0 for a single entry); the model derives ctrl/toggle/done itself.
  task automatic check_run(input int n, input int ta, input int tb, input logic init);
    logic c;
    logic tg;
    int   last;
    c    = init;
    last = (tb >= 0) ? tb : ta;
    for (int k = 1; k <= n; k++) begin
      step();
      tg = (k == ta + 1) || ((tb >= 0) && (k == tb + 1));
      if (tg) c = ~c;
      check($sformatf("toggle@E%0d", k), toggle, tg);
      check($sformatf("ctrl@E%0d", k), ctrl, c);
      check($sformatf("done@E%0d", k), done, (k >= last + 1));
      check($sformatf("busy@E%0d", k), busy, (k < last + 1));
    end
    $display("run %0d edges: ctrl=%0d index=%0d done=%0d", n, ctrl, index, done);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load_valid = 1'b0; load_time = '0;
    init_state = 1'b0; start = 1'b0; abort = 1'b0;
    step();
    step();
    reset = 1'b0;

    // reset state
    check("rst_ctrl", ctrl, 0);
    check("rst_toggle", toggle, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_index", index, 0);
    check("rst_count", count, 0);
    check("rst_order_err", order_err, 0);
    check("rst_load_ready", load_ready, 1);

    // two entries, normal run
    load(3);
    load(5);
    check("t1_count", count, 2);
    init_state = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy_E0", busy, 1);
    check("t1_ctrl_E0", ctrl, 0);
    check("t1_toggle_E0", toggle, 0);
    check("t1_index_E0", index, 0);
    check_run(7, 3, 5, 1'b0);
    check("t1_index_end", index, 2);
    check("t1_load_ready_done", load_ready, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_start_in_done_ignored", done, 1);
    do_clear();
    check("t1_clear_done", done, 0);
    check("t1_clear_count", count, 0);
    check("t1_clear_index", index, 0);

    // zero entry, init high
    load(0);
    init_state = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    init_state = 1'b0;
    check("t2_ctrl_E0", ctrl, 1);
    check_run(1, 0, -1, 1'b1);
    check("t2_index", index, 1);
    do_clear();
    check("t2_ctrl_held", ctrl, 0);

    // ordering and fill
    load(10);
    load(10);
    load(4);
    load(20);
    check("t3_count", count, 2);
    check("t3_order_err", order_err, 1);
    for (int i = 0; i < DEPTH - 2; i++) load(TW'(21 + i));
    check("t3_count_full", count, DEPTH);
    check("t3_load_ready_full", load_ready, 0);
    load(100);
    check("t3_count_no_overflow", count, DEPTH);
    do_clear();
    check("t3_clear_count", count, 0);
    check("t3_clear_order_err", order_err, 0);
    check("t3_load_ready_after_clear", load_ready, 1);

    // abort on a coincident hit, then restart
    load(2);
    load(8);
    init_state = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_run(8, 2, 8, 1'b0);
    check("t4_ctrl_before_abort", ctrl, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_toggle", toggle, 0);
    check("t4_abort_ctrl", ctrl, 0);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_index", index, 0);
    check("t4_abort_count", count, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_restart_busy", busy, 1);
    check_run(10, 2, 8, 1'b0);
    check("t4_restart_index", index, 2);
    do_clear();

    // load and start in the same cycle with an empty list
    load_valid = 1'b1;
    load_time  = 7;
    start      = 1'b1;
    init_state = 1'b0;
    step();
    load_valid = 1'b0;
    start      = 1'b0;
    check("t5_busy", busy, 1);
    check("t5_count", count, 1);
    check_run(8, 7, -1, 1'b0);
    // clear + start from DONE
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    check("t5_clrstart_busy", busy, 0);
    check("t5_clrstart_done", done, 0);
    check("t5_clrstart_count", count, 0);
    // clear + start + load from IDLE with a non-empty list
    load(4);
    clear = 1'b1;
    start = 1'b1;
    load_valid = 1'b1;
    load_time = 9;
    step();
    clear = 1'b0;
    start = 1'b0;
    load_valid = 1'b0;
    check("t5_clr_idle_busy", busy, 0);
    check("t5_clr_idle_count", count, 0);

    // reset mid-run
    load(5);
    init_state = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    init_state = 1'b0;
    check("t6_ctrl_E0", ctrl, 1);
    step();
    check("t6_toggle_E1", toggle, 0);
    step();
    check("t6_toggle_E2", toggle, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_ctrl", ctrl, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_toggle", toggle, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("t6_no_toggle_%0d", k), toggle, 0);
    end
    check("t6_ctrl_final", ctrl, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
